// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle program counter sequencing FSM
// Drives PC write enable/value, fetch requests, interrupt entry and return.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0010,
    parameter logic [15:0] PC_INC       = 16'd2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] input_PCC_pc,
    input  logic        input_PCC_mem_ready,
    input  logic [1:0]  input_PCC_kind,
    input  logic        input_PCC_ret,
    input  logic [15:0] input_PCC_target,
    input  logic        input_PCC_branch_taken,
    input  logic        input_PCC_stall,
    input  logic        input_PCC_irq,
    output logic        output_PCC_PCWrite,
    output logic [15:0] output_PCC_newPC,
    output logic        output_PCC_fetch_req,
    output logic [15:0] output_PCC_epc,
    output logic        output_PCC_in_isr,
    output logic        output_PCC_halted,
    output logic [2:0]  output_PCC_state
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_UPDATE  = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [15:0] next_pc_q, next_pc_d;
    logic [15:0] epc_q, epc_d;
    logic        in_isr_q, in_isr_d;
    logic        ret_q, ret_d;
    logic [1:0]  kind_q, kind_d;

    logic        take_irq;
    logic [15:0] seq_pc;

    assign take_irq = input_PCC_irq & ~in_isr_q;
    assign seq_pc   = input_PCC_pc + PC_INC;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        next_pc_d = next_pc_q;
        epc_d     = epc_q;
        in_isr_d  = in_isr_q;
        ret_d     = ret_q;
        kind_d    = kind_q;
        case (state_q)
            S_INIT:  state_d = S_FETCH;
            S_FETCH: if (input_PCC_mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                target_d = input_PCC_target;
                ret_d    = input_PCC_ret;
                kind_d   = input_PCC_kind;
                if (!input_PCC_ret && input_PCC_kind == 2'b11) state_d = S_HALT;
                else                                            state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (ret_q) begin
                    next_pc_d = epc_q;
                end else begin
                    case (kind_q)
                        2'b01:   next_pc_d = input_PCC_branch_taken ? target_q : seq_pc;
                        2'b10:   next_pc_d = target_q;
                        default: next_pc_d = seq_pc;
                    endcase
                end
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (!input_PCC_stall) begin
                    state_d = S_FETCH;
                    // An interrupt wins over a pending return; the return address is banked.
                    if (take_irq) begin
                        epc_d    = next_pc_q;
                        in_isr_d = 1'b1;
                    end else if (ret_q) begin
                        in_isr_d = 1'b0;
                    end
                end
            end
            S_HALT: begin
                if (take_irq) begin
                    next_pc_d = seq_pc;
                    ret_d     = 1'b0;
                    state_d   = S_UPDATE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_INIT;
            target_q  <= 16'h0000;
            next_pc_q <= 16'h0000;
            epc_q     <= 16'h0000;
            in_isr_q  <= 1'b0;
            ret_q     <= 1'b0;
            kind_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            next_pc_q <= next_pc_d;
            epc_q     <= epc_d;
            in_isr_q  <= in_isr_d;
            ret_q     <= ret_d;
            kind_q    <= kind_d;
        end
    end

    assign output_PCC_PCWrite   = (state_q == S_INIT) || (state_q == S_UPDATE && !input_PCC_stall);
    assign output_PCC_newPC     = (state_q == S_INIT) ? RESET_VECTOR :
                                  (state_q == S_UPDATE && take_irq) ? IRQ_VECTOR : next_pc_q;
    assign output_PCC_fetch_req = (state_q == S_FETCH);
    assign output_PCC_epc       = epc_q;
    assign output_PCC_in_isr    = in_isr_q;
    assign output_PCC_halted    = (state_q == S_HALT);
    assign output_PCC_state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] pc;
    logic        mem_ready, ret, taken, stall, irq;
    logic [1:0]  kind;
    logic [15:0] target;
    logic        PCWrite, fetch_req, in_isr, halted;
    logic [15:0] newPC, epc;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pc_sequencer dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .input_PCC_pc           (pc),
        .input_PCC_mem_ready    (mem_ready),
        .input_PCC_kind         (kind),
        .input_PCC_ret          (ret),
        .input_PCC_target       (target),
        .input_PCC_branch_taken (taken),
        .input_PCC_stall        (stall),
        .input_PCC_irq          (irq),
        .output_PCC_PCWrite     (PCWrite),
        .output_PCC_newPC       (newPC),
        .output_PCC_fetch_req   (fetch_req),
        .output_PCC_epc         (epc),
        .output_PCC_in_isr      (in_isr),
        .output_PCC_halted      (halted),
        .output_PCC_state       (state)
    );

    // One clock; the bench plays the PC register, loading newPC when PCWrite is high.
    task automatic step();
        logic        wr;
        logic [15:0] nv;
        #1;
        wr = PCWrite;
        nv = newPC;
        @(posedge CLK);
        if (wr === 1'b1) pc = nv;
        #1;
    endtask

    // From FETCH with mem_ready=1: run one instruction, report the UPDATE write and the
    // epc/in_isr seen once back in FETCH.
    task automatic run_instr(input logic [1:0] k, input logic r, input logic [15:0] t,
                             input logic tk, input logic iq,
                             output logic wr, output logic [15:0] npc,
                             output logic [15:0] ep, output logic isr);
        kind = k; ret = r; target = t; taken = tk; irq = iq;
        step(); step(); step();
        #1;
        wr  = PCWrite;
        npc = newPC;
        step();
        ep  = epc;
        isr = in_isr;
    endtask

    task automatic test_reset();
        int seq[6];
        RST = 1'b1; mem_ready = 1'b1; kind = 2'b00; ret = 1'b0; target = 16'h0;
        taken = 1'b0; stall = 1'b0; irq = 1'b0; pc = 16'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (state !== 3'd0 || PCWrite !== 1'b1 || newPC !== 16'h0000 || fetch_req !== 1'b0 ||
                epc !== 16'h0 || in_isr !== 1'b0 || halted !== 1'b0) begin
                errors++;
                $display("FAIL reset_vals: state=%0d wr=%b npc=%h fr=%b epc=%h isr=%b h=%b, want 0 1 0000 0 0000 0 0",
                         state, PCWrite, newPC, fetch_req, epc, in_isr, halted);
            end
        end
        RST = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || PCWrite !== 1'b1 || newPC !== 16'h0000) begin
            errors++;
            $display("FAIL init_cycle: state=%0d wr=%b npc=%h, want 0 1 0000", state, PCWrite, newPC);
        end
        seq = '{1, 2, 3, 4, 1, 2};
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (state !== seq[i][2:0]) begin
                errors++;
                $display("FAIL state_seq[%0d]: got %0d, want %0d", i, state, seq[i]);
            end
            if (i == 3) begin
                #1;
                checks++;
                if (PCWrite !== 1'b1 || newPC !== 16'h0002) begin
                    errors++;
                    $display("FAIL first_update: wr=%b npc=%h, want 1 0002", PCWrite, newPC);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic wr, isr;
        logic [15:0] npc, ep;
        int fr_cnt;
        pc = 16'h0040;
        run_instr(2'b01, 1'b0, 16'h0100, 1'b1, 1'b0, wr, npc, ep, isr);
        checks++;
        if (wr !== 1'b1 || npc !== 16'h0100) begin
            errors++;
            $display("FAIL branch_taken: wr=%b npc=%h, want 1 0100", wr, npc);
        end
        pc = 16'h0040;
        run_instr(2'b01, 1'b0, 16'h0100, 1'b0, 1'b0, wr, npc, ep, isr);
        checks++;
        if (wr !== 1'b1 || npc !== 16'h0042) begin
            errors++;
            $display("FAIL branch_not_taken: wr=%b npc=%h, want 1 0042", wr, npc);
        end
        mem_ready = 1'b0;
        kind = 2'b00;
        fr_cnt = 0;
        for (int i = 0; i < 10 && state == 3'd1; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            if (fetch_req === 1'b1) fr_cnt++;
            step();
        end
        checks++;
        if (fr_cnt != 4 || state !== 3'd2) begin
            errors++;
            $display("FAIL mem_wait: fetch_req cycles=%0d state=%0d, want 4 2", fr_cnt, state);
        end
        step(); step(); step();
    endtask

    task automatic test_wrap_jump();
        logic wr, isr;
        logic [15:0] npc, ep;
        pc = 16'hFFFE;
        run_instr(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, wr, npc, ep, isr);
        checks++;
        if (wr !== 1'b1 || npc !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap: wr=%b npc=%h, want 1 0000", wr, npc);
        end
        run_instr(2'b10, 1'b0, 16'h1234, 1'b0, 1'b0, wr, npc, ep, isr);
        checks++;
        if (wr !== 1'b1 || npc !== 16'h1234) begin
            errors++;
            $display("FAIL jump: wr=%b npc=%h, want 1 1234", wr, npc);
        end
    endtask

    task automatic test_irq();
        logic wr, isr;
        logic [15:0] npc, ep;
        pc = 16'h0020;
        run_instr(2'b00, 1'b0, 16'h0, 1'b0, 1'b1, wr, npc, ep, isr);
        checks++;
        if (npc !== 16'h0010 || ep !== 16'h0022 || isr !== 1'b1) begin
            errors++;
            $display("FAIL irq_entry: npc=%h epc=%h isr=%b, want 0010 0022 1", npc, ep, isr);
        end
        run_instr(2'b00, 1'b0, 16'h0, 1'b0, 1'b1, wr, npc, ep, isr);
        checks++;
        if (npc !== 16'h0012 || ep !== 16'h0022 || isr !== 1'b1) begin
            errors++;
            $display("FAIL irq_masked: npc=%h epc=%h isr=%b, want 0012 0022 1", npc, ep, isr);
        end
        run_instr(2'b00, 1'b1, 16'h5555, 1'b0, 1'b0, wr, npc, ep, isr);
        checks++;
        if (wr !== 1'b1 || npc !== 16'h0022 || isr !== 1'b0) begin
            errors++;
            $display("FAIL reti: wr=%b npc=%h isr=%b, want 1 0022 0", wr, npc, isr);
        end
    endtask

    task automatic test_stall_halt();
        int bad;
        logic [15:0] p;
        pc = 16'h0300;
        kind = 2'b00; ret = 1'b0; irq = 1'b0;
        step(); step();
        stall = 1'b1;
        step();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (PCWrite !== 1'b0 || state !== 3'd4) bad++;
            if (i == 4) stall = 1'b0;
            if (i < 4) step();
        end
        #1;
        checks++;
        if (bad != 0 || PCWrite !== 1'b1 || newPC !== 16'h0302) begin
            errors++;
            $display("FAIL stall: bad_cycles=%0d wr=%b npc=%h, want 0 1 0302", bad, PCWrite, newPC);
        end
        step();
        kind = 2'b11;
        step(); step();
        checks++;
        if (halted !== 1'b1 || state !== 3'd5) begin
            errors++;
            $display("FAIL halt_enter: halted=%b state=%0d, want 1 5", halted, state);
        end
        p = pc;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (PCWrite !== 1'b0 || state !== 3'd5) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_hold: %0d bad cycles, want 0", bad);
        end
        irq = 1'b1;
        step();
        #1;
        checks++;
        if (state !== 3'd4 || PCWrite !== 1'b1 || newPC !== 16'h0010) begin
            errors++;
            $display("FAIL halt_irq: state=%0d wr=%b npc=%h, want 4 1 0010", state, PCWrite, newPC);
        end
        step();
        irq = 1'b0;
        checks++;
        if (epc !== p + 16'd2 || in_isr !== 1'b1 || state !== 3'd1) begin
            errors++;
            $display("FAIL halt_epc: epc=%h isr=%b state=%0d, want %h 1 1", epc, in_isr, state, p + 16'd2);
        end
    endtask

    task automatic test_reset_mid();
        logic wr, isr;
        logic [15:0] npc, ep;
        pc = 16'h0400;
        kind = 2'b10; target = 16'h0800;
        step(); step();
        RST = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || epc !== 16'h0 || in_isr !== 1'b0 || PCWrite !== 1'b1 || newPC !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: state=%0d epc=%h isr=%b wr=%b npc=%h, want 0 0000 0 1 0000",
                     state, epc, in_isr, PCWrite, newPC);
        end
        step();
        RST = 1'b0;
        step();
        run_instr(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, wr, npc, ep, isr);
        checks++;
        if (npc !== 16'h0002 || ep !== 16'h0 || isr !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: npc=%h epc=%h isr=%b, want 0002 0000 0", npc, ep, isr);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_wrap_jump();
        test_irq();
        test_stall_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
